// File: rtl/lab3_dg_keypad_pkg.sv
// lab3_dg_keypad_pkg: shared state encoding, key map and row priority helper for the keypad scanner
package lab3_dg_keypad_pkg;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} scan_state_t;

    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [1:0] row_priority(input logic [3:0] rows);
        return rows[0] ? 2'd0 : rows[1] ? 2'd1 : rows[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/lab3_dg_stable_cnt.sv
// lab3_dg_stable_cnt: clear/enable stability counter with a terminal-count flag
module lab3_dg_stable_cnt #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic int_osc,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt_q, cnt_d;

    // clear has priority; enable advances one step per cycle
    always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;

    // count register
    always_ff @(posedge int_osc)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign tc = cnt_q == W'(DEBOUNCE_CYCLES - 1);

endmodule

// File: rtl/lab3_dg_keypad_scanner.sv
// lab3_dg_keypad_scanner: 4x4 keypad column scanner with press/release debounce and key strobe
module lab3_dg_keypad_scanner
    import lab3_dg_keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] sync,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int CW = $clog2(SCAN_DIV > DEBOUNCE_CYCLES ? SCAN_DIV : DEBOUNCE_CYCLES);

    scan_state_t   state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] div_q, div_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          run, tc;

    // the counter only runs while the debounced row stays at the level being confirmed,
    // and is held at zero otherwise so every debounce window starts fresh
    lab3_dg_stable_cnt #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(CW)) u_stable (
        .int_osc (int_osc),
        .reset   (reset),
        .clr     (!run),
        .en      (run),
        .tc      (tc)
    );

    // next-state: scan columns, confirm press, hold, confirm release
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_d       = row_q;
        div_d       = div_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        run         = 1'b0;
        case (state_q)
            SCAN: begin
                div_d = div_q == CW'(SCAN_DIV - 1) ? '0 : div_q + CW'(1);
                if (div_q == CW'(SCAN_DIV - 1)) begin
                    if (|sync) begin
                        row_d   = row_priority(sync);
                        state_d = PRESS_DB;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            PRESS_DB: begin
                if (!sync[row_q]) begin
                    state_d = SCAN;
                    div_d   = '0;
                end else if (tc) begin
                    state_d     = HELD;
                    key_d       = KEYMAP[row_q][col_idx_q];
                    key_valid_d = 1'b1;
                end else begin
                    run = 1'b1;
                end
            end
            HELD: state_d = sync[row_q] ? HELD : RELEASE_DB;
            RELEASE_DB: begin
                if (sync[row_q]) begin
                    state_d = HELD;
                end else if (tc) begin
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    div_d     = '0;
                end else begin
                    run = 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge int_osc) begin
        if (reset) begin
            state_q     <= SCAN;
            col_idx_q   <= '0;
            row_q       <= '0;
            div_q       <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_q       <= row_d;
            div_q       <= div_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col       = 4'b0001 << col_idx_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_lab3_dg_keypad_scanner.sv
// tb_lab3_dg_keypad_scanner: directed self-checking bench for the keypad scanner
module tb_lab3_dg_keypad_scanner;

    logic       int_osc = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] sync    = 4'b0000;
    logic [3:0] col, key;
    logic       key_valid;
    int         tests = 0;
    int         fails = 0;

    lab3_dg_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .int_osc   (int_osc),
        .reset     (reset),
        .sync      (sync),
        .col       (col),
        .key       (key),
        .key_valid (key_valid)
    );

    always #5 int_osc = ~int_osc;

    // waits for col to newly become c, so the divider is at 0 on return
    task automatic wait_col(input logic [3:0] c);
        int n = 0;
        while (col == c && n < 64) begin @(negedge int_osc); n++; end
        while (col != c && n < 64) begin @(negedge int_osc); n++; end
        tests++;
        if (col !== c) begin
            fails++;
            $display("FAIL wait_col: col=%b required %b within 64 cycles", col, c);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        sync  = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge int_osc);
            @(negedge int_osc);
            tests++;
            if (col !== 4'b0001 || key !== 4'h0 || key_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset[%0d]: col=%b key=%h kv=%b required 0001 0 0", i, col, key, key_valid);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_scan;
        logic [3:0] exp;
        for (int i = 0; i < 20; i++) begin
            exp = 4'b0001 << ((i / 4) % 4);
            tests++;
            if (col !== exp || key_valid !== 1'b0) begin
                fails++;
                $display("FAIL scan[%0d]: col=%b kv=%b required %b 0", i, col, key_valid, exp);
            end
            @(negedge int_osc);
        end
    endtask

    task automatic test_press_hold;
        int pulses = 0;
        int lat = 0;
        wait_col(4'b0100);
        sync = 4'b0010;
        for (int i = 1; i <= 30; i++) begin
            @(negedge int_osc);
            if (key_valid) begin pulses++; if (lat == 0) lat = i; end
            tests++;
            if (col !== 4'b0100) begin
                fails++;
                $display("FAIL hold_col[%0d]: col=%b required 0100", i, col);
            end
        end
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL press_pulses: got %0d required 1", pulses); end
        tests++;
        if (lat != 12) begin fails++; $display("FAIL press_latency: got %0d required 12", lat); end
        tests++;
        if (key !== 4'h6) begin fails++; $display("FAIL press_key: got %h required 6", key); end
    endtask

    task automatic test_held_glitch;
        sync = 4'b0000;
        repeat (2) @(negedge int_osc);
        sync = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            @(negedge int_osc);
            tests++;
            if (key_valid !== 1'b0 || col !== 4'b0100) begin
                fails++;
                $display("FAIL glitch[%0d]: kv=%b col=%b required 0 0100", i, key_valid, col);
            end
        end
        sync = 4'b0000;
        for (int i = 0; i < 11; i++) begin
            @(negedge int_osc);
            tests++;
            if (key_valid !== 1'b0) begin
                fails++;
                $display("FAIL release_kv[%0d]: kv=%b required 0", i, key_valid);
            end
        end
        tests++;
        if (col !== 4'b1000) begin fails++; $display("FAIL release_col: col=%b required 1000", col); end
    endtask

    task automatic test_bounce;
        wait_col(4'b0010);
        sync = 4'b0100;
        repeat (7) @(negedge int_osc);
        sync = 4'b0000;
        @(negedge int_osc);
        tests++;
        if (col !== 4'b0010) begin fails++; $display("FAIL bounce_same_col: col=%b required 0010", col); end
        repeat (3) @(negedge int_osc);
        tests++;
        if (col !== 4'b0010) begin fails++; $display("FAIL bounce_dwell: col=%b required 0010", col); end
        @(negedge int_osc);
        tests++;
        if (col !== 4'b0100) begin fails++; $display("FAIL bounce_advance: col=%b required 0100", col); end
        for (int i = 0; i < 12; i++) begin
            @(negedge int_osc);
            tests++;
            if (key_valid !== 1'b0) begin fails++; $display("FAIL bounce_kv[%0d]: kv=%b required 0", i, key_valid); end
        end
        tests++;
        if (key !== 4'h6) begin fails++; $display("FAIL bounce_key_hold: key=%h required 6", key); end
    endtask

    task automatic test_priority;
        int pulses = 0;
        wait_col(4'b0001);
        sync = 4'b0101;
        repeat (16) begin
            @(negedge int_osc);
            if (key_valid) pulses++;
        end
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL prio_pulses: got %0d required 1", pulses); end
        tests++;
        if (key !== 4'h1) begin fails++; $display("FAIL prio_key: got %h required 1", key); end
        sync = 4'b0000;
        repeat (12) @(negedge int_osc);
    endtask

    task automatic test_reset_mid;
        wait_col(4'b0001);
        sync = 4'b1000;
        repeat (6) @(negedge int_osc);
        reset = 1'b1;
        sync  = 4'b0000;
        @(negedge int_osc);
        tests++;
        if (col !== 4'b0001 || key !== 4'h0 || key_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: col=%b key=%h kv=%b required 0001 0 0", col, key, key_valid);
        end
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge int_osc);
            tests++;
            if (key_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_kv[%0d]: kv=%b required 0", i, key_valid); end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_press_hold;
        test_held_glitch;
        test_bounce;
        test_priority;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
